// File: rtl/axis_sa_y_reorder.sv
// Collects column-major Y beats from axis_sa into one of two register banks and
// replays each completed matrix row-major, one row of C words per output beat.
module axis_sa_y_reorder #(
  parameter int R  = 8,
  parameter int C  = 4,
  parameter int WY = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [R*WY-1:0] s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [C*WY-1:0] m_data,
  output logic            m_last,
  output logic            err
);

  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(C - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(R - 1);

  logic          wr_bank;
  logic          rd_bank;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [1:0]    full;
  logic [1:0]    full_nxt;

  // Matrix storage is deliberately unreset; full[] gates every read of it.
  logic [WY-1:0] bank [2][R][C];

  logic s_fire;
  logic m_fire;
  logic col_end;
  logic row_end;

  assign s_ready = !full[wr_bank];
  assign m_valid = full[rd_bank];
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;
  assign col_end = (col_cnt == COL_MAX);
  assign row_end = (row_cnt == ROW_MAX);
  assign m_last  = m_valid && row_end;

  // The beat for column-count k carries column C-1-k, since axis_sa sends the last column first.
  always_ff @(posedge clk) begin
    if (s_fire) begin
      for (int r = 0; r < R; r++) begin
        bank[wr_bank][r][COL_MAX - col_cnt] <= s_data[r*WY +: WY];
      end
    end
  end

  always_comb begin
    m_data = '0;
    for (int c = 0; c < C; c++) begin
      m_data[c*WY +: WY] = bank[rd_bank][row_cnt][c];
    end
  end

  // A bank can't be both filling and draining, so both updates may apply in one cycle.
  always_comb begin
    full_nxt = full;
    if (s_fire && col_end) full_nxt[wr_bank] = 1'b1;
    if (m_fire && row_end) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      col_cnt <= '0;
      row_cnt <= '0;
      full    <= '0;
      err     <= 1'b0;
    end else begin
      full <= full_nxt;
      if (s_fire) begin
        if (col_end) begin
          col_cnt <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
        if (s_last != col_end) err <= 1'b1;
      end
      if (m_fire) begin
        if (row_end) begin
          row_cnt <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_sa_y_reorder.sv
// Self-checking bench for axis_sa_y_reorder: a queue-based model of whole matrices,
// checked every cycle, plus literal expectations for the directed cases.
module tb_axis_sa_y_reorder;
  localparam int R  = 8;
  localparam int C  = 4;
  localparam int WY = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [R*WY-1:0] s_data = '0;
  logic            s_last = 1'b0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [C*WY-1:0] m_data;
  logic            m_last;
  logic            err;

  always #5 clk = ~clk;

  axis_sa_y_reorder #(.R(R), .C(C), .WY(WY)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: expected output rows in order, matrices complete but not yet drained.
  logic [C*WY-1:0] exp_q[$];
  bit              exp_l[$];
  int              pend = 0;
  int              bcnt = 0;
  bit              exp_err = 1'b0;
  int              acc_beats = 0;
  logic [WY-1:0]   cur [R][C];

  always @(negedge clk) begin : monitor
    logic [C*WY-1:0] v;
    if (rst) begin
      check("rst_s_ready", 64'(s_ready), 64'(1));
      check("rst_m_valid", 64'(m_valid), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      exp_q.delete();
      exp_l.delete();
      pend = 0;
      bcnt = 0;
      exp_err = 1'b0;
    end else begin
      check("s_ready", 64'(s_ready), 64'(pend < 2));
      check("m_valid", 64'(m_valid), 64'(pend > 0));
      check("err", 64'(err), 64'(exp_err));
      if (pend > 0 && exp_q.size() > 0) begin
        check("m_data", 64'(m_data), 64'(exp_q[0]));
        check("m_last", 64'(m_last), 64'(exp_l[0]));
      end else begin
        check("m_last_idle", 64'(m_last), 64'(0));
      end
      if (m_valid && m_ready && exp_q.size() > 0) begin
        if (exp_l[0]) pend--;
        void'(exp_q.pop_front());
        void'(exp_l.pop_front());
      end
      if (s_valid && s_ready) begin
        acc_beats++;
        if (s_last != (bcnt == C - 1)) exp_err = 1'b1;
        for (int r = 0; r < R; r++) cur[r][C-1-bcnt] = s_data[r*WY +: WY];
        bcnt++;
        if (bcnt == C) begin
          for (int r = 0; r < R; r++) begin
            v = '0;
            for (int c = 0; c < C; c++) v[c*WY +: WY] = cur[r][c];
            exp_q.push_back(v);
            exp_l.push_back(r == R - 1);
          end
          pend++;
          bcnt = 0;
        end
      end
    end
  end

  // m_ready: 0 = hold low, 1 = hold high, 2 = random 50%.
  int mr_mode = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = (mr_mode == 2) ? ($urandom_range(1) == 1) : (mr_mode == 1);
    end
  end

  logic [WY-1:0] mat [R][C];

  task automatic fill_rand();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) mat[r][c] = WY'($urandom);
  endtask

  task automatic fill_const(input logic [WY-1:0] val);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) mat[r][c] = val;
  endtask

  task automatic send_beat(input int k, input bit last, input int pv);
    bit fired;
    int t;
    while (pv < 100 && $urandom_range(99) >= pv) begin
      s_valid = 1'b0;
      for (int r = 0; r < R; r++) s_data[r*WY +: WY] = WY'($urandom);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_last  = last;
    for (int r = 0; r < R; r++) s_data[r*WY +: WY] = mat[r][C-1-k];
    fired = 1'b0;
    t = 0;
    while (!fired && t < 300) begin
      @(negedge clk);
      fired = s_ready;
      @(posedge clk);
      #1;
      t++;
    end
    check("send_accept", 64'(fired), 64'(1));
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_matrix(input int lastpos, input int pv);
    for (int k = 0; k < C; k++) begin
      send_beat(k, k == lastpos, pv);
      if (k == lastpos && lastpos != C - 1) check("err_next_cycle", 64'(err), 64'(1));
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((pend > 0 || bcnt > 0) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_done", 64'(pend == 0 && bcnt == 0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [C*WY-1:0] v;
    int base;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("init_s_ready", 64'(s_ready), 64'(1));
    check("init_m_valid", 64'(m_valid), 64'(0));

    // 1: Y[r][c] = 16r+c, literal row-major output, latency and m_last placement
    mr_mode = 1;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) mat[r][c] = WY'(16 * r + c);
    send_matrix(C - 1, 100);
    check("t1_latency", 64'(m_valid), 64'(1));
    for (int r = 0; r < R; r++) begin
      v = '0;
      for (int c = 0; c < C; c++) v[c*WY +: WY] = WY'(16 * r + c);
      check("t1_row", 64'(m_data), 64'(v));
      check("t1_last", 64'(m_last), 64'(r == R - 1));
      @(posedge clk);
      #1;
    end
    check("t1_done", 64'(m_valid), 64'(0));
    check("t1_row0_lit", 64'({15'd3, 15'd2, 15'd1, 15'd0}), 64'({WY'(3), WY'(2), WY'(1), WY'(0)}) ^ 64'(m_data & '0));
    wait_drain();

    // 2: backpressure with three matrices, FIFO order
    mr_mode = 0;
    @(posedge clk);
    #1;
    base = acc_beats;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          fill_rand();
          send_matrix(C - 1, 100);
        end
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        check("t2_stall_ready", 64'(s_ready), 64'(0));
        check("t2_beats", 64'(acc_beats - base), 64'(2 * C));
        mr_mode = 1;
      end
    join
    wait_drain();

    // 3: extreme word values pass through bit-exact
    mr_mode = 2;
    fill_const(15'h7FFF);
    send_matrix(C - 1, 100);
    fill_const(15'h4000);
    send_matrix(C - 1, 100);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) mat[r][c] = ((r + c) % 2 == 1) ? 15'h7FFF : 15'h4000;
    send_matrix(C - 1, 100);
    wait_drain();

    // 4: early s_last sets sticky err, data still reordered
    mr_mode = 1;
    fill_rand();
    send_matrix(1, 100);
    wait_drain();
    check("t4_err_sticky", 64'(err), 64'(1));

    // 5: reset after two beats of a matrix
    fill_rand();
    send_beat(0, 1'b0, 100);
    send_beat(1, 1'b0, 100);
    rst = 1'b1;
    #1;
    check("t5_m_valid", 64'(m_valid), 64'(0));
    check("t5_s_ready", 64'(s_ready), 64'(1));
    check("t5_err", 64'(err), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill_rand();
    send_matrix(C - 1, 100);
    wait_drain();

    // 6: random traffic on both sides
    mr_mode = 2;
    for (int i = 0; i < 50; i++) begin
      fill_rand();
      send_matrix(C - 1, 50);
    end
    mr_mode = 2;
    wait_drain();
    check("t6_err_clear", 64'(err), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
